// File: rtl/dff_reg_rr_arbiter.sv
// Round-robin write arbiter owning one shared W-bit register (req/gnt/release handshake).
// Optional release timeout with sticky err flag is built when ARB_TIMEOUT_EN is defined.
module dff_reg_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned OW = 2,
  parameter int unsigned TO = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           busy,
  output logic [OW-1:0]  owner,
  output logic           err
);

  // Elaboration-time parameter sanity checks
  if (N < 2 || N > 16) begin : g_bad_n
    $error("dff_reg_rr_arbiter: N must be 2..16");
  end
  if ((1 << OW) < N) begin : g_bad_ow
    $error("dff_reg_rr_arbiter: OW too narrow for N");
  end
  if (TO < 1) begin : g_bad_to
    $error("dff_reg_rr_arbiter: TO must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_arb;
  logic           w_write;
  logic           w_tmo;
  logic           w_found;
  logic [OW-1:0]  w_idx;
  logic [OW-1:0]  w_winner;
  logic [W-1:0]   w_lanes [N];
  logic [N-1:0]   r_gnt;
  logic [W-1:0]   r_q;
  logic           r_busy;
  logic [OW-1:0]  r_owner;
  logic [OW-1:0]  r_last;
  logic           r_err;

  // Split the flat write-data bus into per-requester lanes
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_lanes[i] = wdata[i*W +: W];
    end
  end

  // Round-robin search starting just after the last winner
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = OW'((32'(r_last) + i) % N);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO + 1);
  logic [CW-1:0] r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    w_write     = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_arb       = 1'b1;
        end
      end
      S_GRANT: begin
        w_state_nxt = S_RELEASE;
        w_write     = 1'b1;
      end
      S_RELEASE: begin
        if (!req[r_owner]) begin
          w_state_nxt = S_IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (r_cnt == CW'(TO - 1)) begin
          w_state_nxt = S_IDLE;
          w_tmo       = 1'b1;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_last  <= OW'(N - 1);
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_gnt  <= w_arb ? ({{(N-1){1'b0}}, 1'b1} << w_winner) : '0;
      if (w_arb) begin
        r_owner <= w_winner;
        r_last  <= w_winner;
      end
      if (w_write) begin
        r_q <= w_lanes[r_owner];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Release timeout counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_write) begin
        r_cnt <= '0;
      end else if (r_state == S_RELEASE) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign r_err = 1'b0;
  logic w_unused_tmo;
  assign w_unused_tmo = w_tmo;
`endif

  assign gnt   = r_gnt;
  assign q     = r_q;
  assign busy  = r_busy;
  assign owner = r_owner;
  assign err   = r_err;

endmodule

// File: tb/tb_dff_reg_rr_arbiter.sv
// Directed self-checking bench for dff_reg_rr_arbiter (N=4, W=8, TO=15).
module tb_dff_reg_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned OW = 2;
  localparam int unsigned TO = 15;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           busy;
  logic [OW-1:0]  owner;
  logic           err;

  int checks;
  int errors;

  dff_reg_rr_arbiter #(.N(N), .W(W), .OW(OW), .TO(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .owner (owner),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int unsigned i, input logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_lane(i, 8'hF0 + 8'(i));
    tick();
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    req = '0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_lane(2, 8'hA5);
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner got %0d exp 2", owner); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL single_q_early got %h exp 00", q); end
    req = 4'b0000;
    tick();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL single_q got %h exp a5", q); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse got %b exp 0000", gnt); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b exp 0", busy); end
    checks++; if (owner !== 2'd2 || q !== 8'hA5) begin
      errors++; $display("FAIL single_hold got owner=%0d q=%h exp 2 a5", owner, q);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_gnt;
    int unsigned  idx;
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      idx = k % N;
      exp_gnt = '0;
      exp_gnt[idx] = 1'b1;
      tick();
      checks++; if (gnt !== exp_gnt || owner !== OW'(idx)) begin
        errors++; $display("FAIL rr_grant[%0d] got gnt=%b owner=%0d exp %b %0d", k, gnt, owner, exp_gnt, idx);
      end
      tick();
      checks++; if (q !== 8'h10 + 8'(idx)) begin
        errors++; $display("FAIL rr_q[%0d] got %h exp %h", k, q, 8'h10 + 8'(idx));
      end
      req[idx] = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin
        errors++; $display("FAIL rr_release[%0d] got busy=%b exp 0", k, busy);
      end
      req = 4'b1111;
    end
    req = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0101;
    tick();
    checks++; if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++; $display("FAIL collision_first got gnt=%b owner=%0d exp 0001 0", gnt, owner);
    end
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0101;
    tick();
    checks++; if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++; $display("FAIL collision_second got gnt=%b owner=%0d exp 0100 2", gnt, owner);
    end
    req = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_lane(1, 8'h5C);
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt got %b exp 0010", gnt); end
    rst = 1'b0;
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_q got %h exp 00", q); end
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_outputs got gnt=%b busy=%b exp 0000 0", gnt, busy);
    end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL mid_owner got %0d exp 0", owner); end
    rst = 1'b1;
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_rearb got %b exp 0010", gnt); end
    req = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    set_lane(0, 8'h3E);
    req = 4'b0001;
    tick();
    tick();
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    checks++; if (busy !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL hold_pre got busy=%b err=%b exp 1 0", busy, err);
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    checks++; if (busy !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL timeout_fire got busy=%b err=%b exp 0 1", busy, err);
    end
    req = '0;
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", err); end
`else
    checks++; if (busy !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL hold_wait got busy=%b err=%b exp 1 0", busy, err);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (busy !== 1'b1 || q !== 8'h3E) begin
      errors++; $display("FAIL hold_long got busy=%b q=%h exp 1 3e", busy, q);
    end
    req = '0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_release got busy=%b exp 0", busy); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    req    = '0;
    wdata  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_reset_mid();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
